// File: rtl/startup_screen_ctrl_if.sv
// Per-pixel and control signals between the startup-screen controller and its surroundings.
// The controller sits on the slave side; the video/game environment drives the master side.
interface startup_screen_ctrl_if;
    logic        video_on;
    logic        frame_tick;
    logic        in_title;
    logic        in_start;
    logic        key_any;
    logic        game_over;
    logic [11:0] rgb;
    logic        start_game;
    logic        on_startup;

    modport master (
        output video_on, frame_tick, in_title, in_start, key_any, game_over,
        input  rgb, start_game, on_startup
    );

    modport slave (
        input  video_on, frame_tick, in_title, in_start, key_any, game_over,
        output rgb, start_game, on_startup
    );
endinterface

// File: rtl/startup_screen_ctrl.sv
// Attract-screen FSM (wait release, blinking prompt, debounced start, launch flash) plus 1-cycle registered RGB path.
// Latency: rgb one cycle after its inputs; no backpressure. Optional title fade-in: define STARTUP_FADE_EN.
module startup_screen_ctrl #(
    parameter int          BLINK_FRAMES    = 30,
    parameter int          DEBOUNCE_FRAMES = 3,
    parameter int          LAUNCH_FRAMES   = 20,
    parameter logic [11:0] TITLE_COLOR     = 12'h0F0,
    parameter logic [11:0] FG_COLOR        = 12'hFFF,
    parameter logic [11:0] BG_COLOR        = 12'h000
) (
    input  logic                 clk_0,
    input  logic                 rst,
    startup_screen_ctrl_if.slave scr
);

    localparam int DBW = $clog2(DEBOUNCE_FRAMES + 1);
    localparam int BLW = $clog2(BLINK_FRAMES + 1);
    localparam int LNW = $clog2(LAUNCH_FRAMES + 1);

    localparam logic [DBW-1:0] DB_MAX  = DBW'(DEBOUNCE_FRAMES);
    localparam logic [BLW-1:0] BL_LAST = BLW'(BLINK_FRAMES - 1);
    localparam logic [LNW-1:0] LN_MAX  = LNW'(LAUNCH_FRAMES);

    typedef enum logic [1:0] {
        S_WAIT_RELEASE,
        S_ATTRACT,
        S_LAUNCH,
        S_PLAYING
    } state_t;

    state_t         r_state,      w_state_nxt;
    logic [DBW-1:0] r_dbnc,       w_dbnc_nxt,       w_dbnc_inc;
    logic [BLW-1:0] r_blink_cnt,  w_blink_cnt_nxt;
    logic           r_blink_vis,  w_blink_vis_nxt;
    logic [LNW-1:0] r_launch_cnt, w_launch_cnt_nxt, w_launch_inc;
    logic           r_start_game, w_start_nxt;
    logic           r_on_startup;
    logic [11:0]    r_rgb,        w_rgb_nxt;
    logic [11:0]    w_title_rgb;

    assign w_dbnc_inc   = (r_dbnc == DB_MAX)       ? r_dbnc       : r_dbnc + DBW'(1);
    assign w_launch_inc = (r_launch_cnt == LN_MAX) ? r_launch_cnt : r_launch_cnt + LNW'(1);

    always_comb begin
        w_state_nxt      = r_state;
        w_dbnc_nxt       = r_dbnc;
        w_blink_cnt_nxt  = r_blink_cnt;
        w_blink_vis_nxt  = r_blink_vis;
        w_launch_cnt_nxt = r_launch_cnt;
        w_start_nxt      = 1'b0;

        case (r_state)
            S_WAIT_RELEASE: begin
                w_blink_vis_nxt = 1'b1;
                if (scr.frame_tick) begin
                    if (scr.key_any) begin
                        w_dbnc_nxt = '0;
                    end else begin
                        w_dbnc_nxt = w_dbnc_inc;
                        if (w_dbnc_inc == DB_MAX)
                            w_state_nxt = S_ATTRACT;
                    end
                end
            end
            S_ATTRACT: begin
                if (scr.frame_tick) begin
                    if (r_blink_cnt == BL_LAST) begin
                        w_blink_cnt_nxt = '0;
                        w_blink_vis_nxt = ~r_blink_vis;
                    end else begin
                        w_blink_cnt_nxt = r_blink_cnt + BLW'(1);
                    end
                    if (!scr.key_any) begin
                        w_dbnc_nxt = '0;
                    end else begin
                        w_dbnc_nxt = w_dbnc_inc;
                        if (w_dbnc_inc == DB_MAX)
                            w_state_nxt = S_LAUNCH;
                    end
                end
            end
            S_LAUNCH: begin
                if (scr.frame_tick) begin
                    w_blink_vis_nxt  = ~r_blink_vis;
                    w_launch_cnt_nxt = w_launch_inc;
                    if (w_launch_inc == LN_MAX) begin
                        w_state_nxt = S_PLAYING;
                        w_start_nxt = 1'b1;
                    end
                end
            end
            S_PLAYING: begin
                if (scr.game_over)
                    w_state_nxt = S_WAIT_RELEASE;
            end
            default: w_state_nxt = S_WAIT_RELEASE;
        endcase

        // Every state entry starts its counters fresh; the prompt is visible on entry to the idle states.
        if (w_state_nxt != r_state) begin
            w_dbnc_nxt       = '0;
            w_launch_cnt_nxt = '0;
            if (w_state_nxt == S_ATTRACT || w_state_nxt == S_WAIT_RELEASE) begin
                w_blink_vis_nxt = 1'b1;
                w_blink_cnt_nxt = '0;
            end
        end
    end

`ifdef STARTUP_FADE_EN
    logic [3:0] r_fade, w_fade_nxt;

    function automatic logic [3:0] min4(input logic [3:0] a, input logic [3:0] b);
        return (a < b) ? a : b;
    endfunction

    always_comb begin
        w_fade_nxt = r_fade;
        case (w_state_nxt)
            S_ATTRACT: begin
                if (r_state != S_ATTRACT)
                    w_fade_nxt = '0;
                else if (scr.frame_tick && r_fade != 4'hF)
                    w_fade_nxt = r_fade + 4'd1;
            end
            S_LAUNCH:       w_fade_nxt = 4'hF;
            S_WAIT_RELEASE: w_fade_nxt = '0;
            default:        w_fade_nxt = r_fade;
        endcase
    end

    always_ff @(posedge clk_0) begin
        if (!rst)
            r_fade <= '0;
        else
            r_fade <= w_fade_nxt;
    end

    assign w_title_rgb = {min4(TITLE_COLOR[11:8], r_fade),
                          min4(TITLE_COLOR[7:4],  r_fade),
                          min4(TITLE_COLOR[3:0],  r_fade)};
`else
    assign w_title_rgb = TITLE_COLOR;
`endif

    always_comb begin
        if (!scr.video_on)
            w_rgb_nxt = '0;
        else if (r_state == S_PLAYING)
            w_rgb_nxt = '0;
        else if (scr.in_title)
            w_rgb_nxt = w_title_rgb;
        else if (scr.in_start && r_blink_vis)
            w_rgb_nxt = FG_COLOR;
        else
            w_rgb_nxt = BG_COLOR;
    end

    always_ff @(posedge clk_0) begin
        if (!rst) begin
            r_state      <= S_WAIT_RELEASE;
            r_dbnc       <= '0;
            r_blink_cnt  <= '0;
            r_blink_vis  <= 1'b1;
            r_launch_cnt <= '0;
            r_start_game <= 1'b0;
            r_on_startup <= 1'b1;
            r_rgb        <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_dbnc       <= w_dbnc_nxt;
            r_blink_cnt  <= w_blink_cnt_nxt;
            r_blink_vis  <= w_blink_vis_nxt;
            r_launch_cnt <= w_launch_cnt_nxt;
            r_start_game <= w_start_nxt;
            r_on_startup <= (w_state_nxt != S_PLAYING);
            r_rgb        <= w_rgb_nxt;
        end
    end

    assign scr.rgb        = r_rgb;
    assign scr.start_game = r_start_game;
    assign scr.on_startup = r_on_startup;

endmodule

// File: tb/tb_startup_screen_ctrl.sv
// Bench for startup_screen_ctrl: directed scenarios plus randomized traffic, every cycle checked
// against a frame-count based reference model.
module tb_startup_screen_ctrl;

    localparam int          BLINK_FRAMES  = 30;
    localparam int          DEB_FRAMES    = 3;
    localparam int          LAUNCH_FRAMES = 20;
    localparam logic [11:0] TITLE_COLOR   = 12'h0F0;
    localparam logic [11:0] FG_COLOR      = 12'hFFF;

    logic clk_0 = 1'b0;
    logic rst;
    always #5 clk_0 = ~clk_0;

    startup_screen_ctrl_if scr();

    startup_screen_ctrl dut (
        .clk_0 (clk_0),
        .rst   (rst),
        .scr   (scr)
    );

    int n_total = 0;
    int n_bad   = 0;
    int n_start = 0;
    bit hold_pix = 1'b0;

    // Reference model: mode 0 idle/wait, 1 attract, 2 launch, 3 playing.
    int          m_mode  = 0;
    int          m_run   = 0;
    int          m_ticks = 0;
    bit          m_base  = 1'b1;
    logic [11:0] e_rgb   = '0;
    logic        e_start = 1'b0;
    logic        e_on    = 1'b1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_vis();
        case (m_mode)
            1:       return ((m_ticks / BLINK_FRAMES) % 2) == 0;
            2:       return m_base ^ bit'(m_ticks % 2);
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] m_fade();
        case (m_mode)
            1:       return (m_ticks > 15) ? 4'hF : 4'(m_ticks);
            2:       return 4'hF;
            default: return 4'h0;
        endcase
    endfunction

    function automatic logic [11:0] m_title();
        logic [11:0] r;
        logic [11:0] t;
        logic [3:0]  f;
        r = '0;
        t = TITLE_COLOR;
        f = m_fade();
`ifdef STARTUP_FADE_EN
        for (int c = 0; c < 3; c++)
            r[4*c +: 4] = (t[4*c +: 4] > f) ? f : t[4*c +: 4];
`else
        r = t;
`endif
        return r;
    endfunction

    task automatic model_update();
        logic [11:0] px;
        if (!scr.video_on)                  px = '0;
        else if (m_mode == 3)               px = '0;
        else if (scr.in_title)              px = m_title();
        else if (scr.in_start && m_vis())   px = FG_COLOR;
        else                                px = '0;

        if (!rst) begin
            m_mode = 0; m_run = 0; m_ticks = 0;
            e_rgb = '0; e_start = 1'b0;
        end else begin
            e_rgb   = px;
            e_start = 1'b0;
            case (m_mode)
                0: if (scr.frame_tick) begin
                    m_run = scr.key_any ? 0 : m_run + 1;
                    if (m_run == DEB_FRAMES) begin
                        m_mode = 1; m_run = 0; m_ticks = 0;
                    end
                end
                1: if (scr.frame_tick) begin
                    m_ticks++;
                    m_run = scr.key_any ? m_run + 1 : 0;
                    if (m_run == DEB_FRAMES) begin
                        m_base = ((m_ticks / BLINK_FRAMES) % 2) == 0;
                        m_mode = 2; m_run = 0; m_ticks = 0;
                    end
                end
                2: if (scr.frame_tick) begin
                    m_ticks++;
                    if (m_ticks == LAUNCH_FRAMES) begin
                        m_mode = 3; e_start = 1'b1;
                    end
                end
                default: if (scr.game_over) begin
                    m_mode = 0; m_run = 0;
                end
            endcase
        end
        e_on = (m_mode != 3);
    endtask

    task automatic step();
        if (!hold_pix) begin
            scr.video_on = ($urandom_range(0, 3) != 0);
            scr.in_title = 1'($urandom_range(0, 1));
            scr.in_start = 1'($urandom_range(0, 1));
        end
        model_update();
        @(posedge clk_0);
        #1;
        if (scr.start_game) n_start++;
        chk("rgb",        32'(scr.rgb),        32'(e_rgb));
        chk("start_game", 32'(scr.start_game), 32'(e_start));
        chk("on_startup", 32'(scr.on_startup), 32'(e_on));
    endtask

    task automatic frame(input bit key, input int idle);
        scr.key_any    = key;
        scr.frame_tick = 1'b1;
        step();
        scr.frame_tick = 1'b0;
        repeat (idle) step();
    endtask

    task automatic set_pix(input bit vo, input bit ti, input bit st);
        hold_pix     = 1'b1;
        scr.video_on = vo;
        scr.in_title = ti;
        scr.in_start = st;
    endtask

    initial begin
        logic [11:0] exp_title_wait;
        logic [11:0] exp_title_fade4;
        bit kv;
        int hold;
`ifdef STARTUP_FADE_EN
        exp_title_wait  = 12'h000;
        exp_title_fade4 = 12'h040;
`else
        exp_title_wait  = 12'h0F0;
        exp_title_fade4 = 12'h0F0;
`endif
        rst            = 1'b0;
        scr.video_on   = 1'b0;
        scr.frame_tick = 1'b0;
        scr.in_title   = 1'b0;
        scr.in_start   = 1'b0;
        scr.key_any    = 1'b1;
        scr.game_over  = 1'b0;

        repeat (3) step();
        chk("reset_rgb", 32'(scr.rgb),        32'h0);
        chk("reset_on",  32'(scr.on_startup), 32'h1);
        rst = 1'b1;

        // Key held through reset: must stay waiting for release
        repeat (5) frame(1'b1, 3);
        repeat (3) frame(1'b0, 3);
        chk("attract_on", 32'(scr.on_startup), 32'h1);

        set_pix(1'b1, 1'b0, 1'b1);
        step();
        chk("prompt_vis", 32'(scr.rgb), 32'hFFF);
        repeat (BLINK_FRAMES) frame(1'b0, 2);
        chk("prompt_hidden", 32'(scr.rgb), 32'h000);
        repeat (BLINK_FRAMES) frame(1'b0, 2);
        chk("prompt_back", 32'(scr.rgb), 32'hFFF);

        hold_pix = 1'b0;
        frame(1'b1, 2); frame(1'b1, 2); frame(1'b0, 2);
        frame(1'b1, 2); frame(1'b1, 2); frame(1'b1, 2);
        n_start = 0;
        repeat (LAUNCH_FRAMES - 1) frame(1'($urandom_range(0, 1)), 2);
        chk("pre_start_count", 32'(n_start), 32'h0);
        scr.frame_tick = 1'b1;
        step();
        scr.frame_tick = 1'b0;
        chk("launch_start", 32'(scr.start_game), 32'h1);
        chk("launch_on",    32'(scr.on_startup), 32'h0);
        step();
        chk("start_width", 32'(scr.start_game), 32'h0);
        chk("start_count", 32'(n_start),        32'h1);

        set_pix(1'b1, 1'b1, 1'b0);
        step();
        chk("play_black", 32'(scr.rgb), 32'h000);
        scr.game_over  = 1'b1;
        scr.frame_tick = 1'b1;
        step();
        scr.game_over  = 1'b0;
        scr.frame_tick = 1'b0;
        chk("game_over_exit", 32'(scr.on_startup), 32'h1);

        set_pix(1'b0, 1'b1, 1'b1);
        step();
        chk("blank_prio", 32'(scr.rgb), 32'h000);
        set_pix(1'b1, 1'b1, 1'b1);
        step();
        chk("title_prio", 32'(scr.rgb), 32'(exp_title_wait));

        repeat (3) frame(1'b0, 2);
        set_pix(1'b1, 1'b1, 1'b0);
        repeat (4) frame(1'b0, 2);
        chk("title_fade4", 32'(scr.rgb), 32'(exp_title_fade4));

        // Reset in the middle of the launch flash must suppress the start pulse
        hold_pix = 1'b0;
        repeat (3) frame(1'b1, 2);
        repeat (10) frame(1'b1, 2);
        n_start = 0;
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("mid_reset_rgb", 32'(scr.rgb),        32'h0);
        chk("mid_reset_on",  32'(scr.on_startup), 32'h1);
        repeat (LAUNCH_FRAMES + 5) frame(1'b1, 2);
        chk("mid_reset_nostart", 32'(n_start), 32'h0);

        kv   = 1'b0;
        hold = 0;
        for (int i = 0; i < 4000; i++) begin
            if (hold == 0) begin
                kv   = 1'($urandom_range(0, 1));
                hold = $urandom_range(1, 40);
            end else begin
                hold--;
            end
            scr.key_any    = kv;
            scr.frame_tick = ($urandom_range(0, 3) == 0);
            scr.game_over  = ($urandom_range(0, 29) == 0);
            rst            = ($urandom_range(0, 599) != 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/startup_screen_ctrl.md
Name: startup_screen_ctrl

Overview:
Downstream consumer of the startup text generator's per-pixel hit flags (title and "Press any key to start").
- Runs the attract-screen state machine: waits for key release, blinks the prompt, debounces a key press, plays a short launch flash, then hands control to the game.
- Produces the registered 12-bit RGB pixel for the startup screen and a one-cycle start_game pulse.

Parameters:
BLINK_FRAMES, 30, frames per prompt visibility toggle in ATTRACT
DEBOUNCE_FRAMES, 3, consecutive frame_tick samples required to accept a key level
LAUNCH_FRAMES, 20, frames spent in LAUNCH before start_game
TITLE_COLOR, 12'h0F0, RGB444 colour of title pixels
FG_COLOR, 12'hFFF, RGB444 colour of visible prompt pixels
BG_COLOR, 12'h000, background colour

Ports:
clk_0  in  1  pixel clock
rst  in  1  synchronous reset, active-low (asserted when 0)
video_on  in  1  high in the visible area
frame_tick  in  1  one-cycle pulse at start of each vblank
in_title  in  1  current pixel lies in title glyph
in_start  in  1  current pixel lies in prompt glyph
key_any  in  1  any-key level, already synchronised to clk_0
game_over  in  1  one-cycle pulse from game logic
rgb  out  12  registered pixel colour
start_game  out  1  one-cycle pulse when the game begins
on_startup  out  1  high in every state except PLAYING

Behaviour:
- Reset (rst=0 at a clk_0 edge):
  - state=WAIT_RELEASE, rgb=0, start_game=0, on_startup=1.
  - All counters 0; blink_vis=1.
- States and transitions:
  - WAIT_RELEASE → ATTRACT: after DEBOUNCE_FRAMES consecutive frame_ticks sample key_any=0. A sample of 1 clears the debounce counter.
  - ATTRACT → LAUNCH: after DEBOUNCE_FRAMES consecutive frame_ticks sample key_any=1. A sample of 0 clears the counter.
  - LAUNCH → PLAYING: counts frame_ticks. On the tick that makes the count equal LAUNCH_FRAMES, it asserts start_game for exactly the next cycle and enters PLAYING.
  - PLAYING → WAIT_RELEASE: on game_over=1.
- Debounce counter:
  - Cleared on every state change.
  - Saturates at DEBOUNCE_FRAMES.
  - key_any is ignored on cycles without frame_tick.
- Blink:
  - Entering ATTRACT sets blink_vis=1 and blink counter=0.
  - Each frame_tick in ATTRACT increments the counter. At BLINK_FRAMES-1 it wraps to 0 and toggles blink_vis.
  - In LAUNCH, blink_vis toggles on every frame_tick.
  - In WAIT_RELEASE, blink_vis is held at 1.
- Pixel path (1-cycle latency; rgb at cycle n+1 reflects inputs at cycle n), priority order:
  1. video_on=0 → 0.
  2. state=PLAYING → 0.
  3. in_title → TITLE_COLOR.
  4. in_start & blink_vis → FG_COLOR.
  5. Otherwise → BG_COLOR.
- on_startup is registered: it reflects the state after the transition, so it goes 0 in the same cycle start_game=1.
- Simultaneous events:
  - game_over wins over frame_tick in the same cycle.
  - game_over outside PLAYING is ignored.
- Counter widths are $clog2(param+1) bits. No counter may wrap past its terminal value.
- Reset mid-LAUNCH: no start_game pulse is produced, and the block returns to WAIT_RELEASE.

Optional Feature:
STARTUP_FADE_EN
- Defined:
  - A 4-bit fade_level resets to 0 on entry to ATTRACT and increments on each frame_tick, saturating at 15. It stays 15 in LAUNCH.
  - Each 4-bit channel of the title colour is output as min(channel, fade_level). This applies in WAIT_RELEASE (fade_level held 0) and ATTRACT.
  - Prompt colour is unaffected.
- Undefined: the title uses TITLE_COLOR immediately; no fade register exists.

Test Plan:
- Reset held with key_any=1, then released; 5 frame_ticks with key_any=1 → state stays WAIT_RELEASE. Then key_any=0 for 3 ticks → ATTRACT on the 3rd tick; on_startup=1.
- In ATTRACT, pixel with in_start=1, video_on=1 → rgb=12'hFFF one cycle later. After 30 frame_ticks → rgb=12'h000 for the same pixel. After 60 → 12'hFFF again.
- key_any pattern 1,1,0,1,1,1 across frame_ticks → LAUNCH entered only on the 6th tick. After 20 further ticks → start_game high for exactly 1 cycle and on_startup=0 in that cycle.
- In PLAYING, in_title=1, video_on=1 → rgb=0. A game_over pulse coincident with frame_tick → WAIT_RELEASE next cycle, on_startup=1.
- in_title=1 and in_start=1 together, video_on=0 → rgb=0. Same pixel with video_on=1 → rgb=12'h0F0.
- Reset asserted at LAUNCH tick 10 → no start_game pulse. rgb=0 and state=WAIT_RELEASE after the edge. With STARTUP_FADE_EN, title reads 12'h040 after the 4th ATTRACT tick.
